// File: rtl/edulent_mem_pkg.sv
// Shared widths, loader FSM state encoding and constants for the edulent memory responder.
package edulent_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } mem_state_t;

    // A requested load length of zero means "fill the whole memory".
    localparam logic [ADDR_W_DEF-1:0] LOAD_LEN_FULL = '0;

endpackage : edulent_mem_pkg

// File: rtl/edulent_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on address collision.
module edulent_ram
    import edulent_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignment samples the pre-write contents, which gives read-first behaviour.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : edulent_ram

// File: rtl/edulent_memory.sv
// Memory responder with boot loader FSM holding the CPU in reset during program load.
// Optional: define EDULENT_LOAD_CHECKSUM_EN to add o_load_checksum (mod-256 sum of loaded bytes).
module edulent_memory
    import edulent_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_write,
    output logic [DATA_W-1:0] o_mem_data_read,
    input  logic              i_load_start,
    input  logic [ADDR_W-1:0] i_load_len,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    output logic              o_load_done,
`ifdef EDULENT_LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] o_load_checksum,
`endif
    output logic              o_cpu_rstn
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_load_done;

    logic              w_start;
    logic              w_load_hs;
    logic              w_cpu_we;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;

    assign w_start   = i_load_start && (r_state != ST_LOAD);
    assign w_load_hs = i_load_valid && (r_state == ST_LOAD);
    assign w_cpu_we  = i_mem_write_enable && (r_state == ST_RUN);

    // Loader and CPU never write in the same state, so a simple mux suffices.
    assign w_ram_we    = w_load_hs || w_cpu_we;
    assign w_ram_waddr = (r_state == ST_LOAD) ? r_ptr : i_mem_addr;
    assign w_ram_wdata = (r_state == ST_LOAD) ? i_load_data : i_mem_data_write;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_BOOT;
            r_ptr       <= '0;
            r_count     <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_BOOT, ST_RUN: begin
                    if (i_load_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_count <= (i_load_len == ADDR_W'(LOAD_LEN_FULL)) ? FULL_COUNT
                                                                          : {1'b0, i_load_len};
                    end
                end
                ST_LOAD: begin
                    if (i_load_valid) begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_count <= r_count - (ADDR_W + 1)'(1);
                        if (r_count == (ADDR_W + 1)'(1)) begin
                            r_state     <= ST_RUN;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

`ifdef EDULENT_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] r_load_checksum;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_load_checksum <= '0;
        end else if (w_start) begin
            r_load_checksum <= '0;
        end else if (w_load_hs) begin
            r_load_checksum <= r_load_checksum + i_load_data;
        end
    end

    assign o_load_checksum = r_load_checksum;
`endif

    edulent_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_we   (w_ram_we),
        .i_waddr(w_ram_waddr),
        .i_wdata(w_ram_wdata),
        .i_raddr(i_mem_addr),
        .o_rdata(o_mem_data_read)
    );

    assign o_load_ready = (r_state == ST_LOAD);
    assign o_load_done  = r_load_done;
    assign o_cpu_rstn   = (r_state == ST_RUN);

endmodule : edulent_memory

// File: tb/tb_edulent_memory.sv
// Directed, table-driven bench for edulent_memory: loader FSM, CPU read/write and reset corners.
module tb_edulent_memory;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_mem_addr;
    logic       i_mem_write_enable;
    logic [7:0] i_mem_data_write;
    logic [7:0] o_mem_data_read;
    logic       i_load_start;
    logic [7:0] i_load_len;
    logic       i_load_valid;
    logic [7:0] i_load_data;
    logic       o_load_ready;
    logic       o_load_done;
    logic       o_cpu_rstn;
`ifdef EDULENT_LOAD_CHECKSUM_EN
    logic [7:0] o_load_checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] exp;
        bit         chk;
    } vec_t;

    vec_t vecs [0:12];

    edulent_memory dut (
        .i_clk             (clk),
        .i_rstn            (rst_n),
        .i_mem_addr        (i_mem_addr),
        .i_mem_write_enable(i_mem_write_enable),
        .i_mem_data_write  (i_mem_data_write),
        .o_mem_data_read   (o_mem_data_read),
        .i_load_start      (i_load_start),
        .i_load_len        (i_load_len),
        .i_load_valid      (i_load_valid),
        .i_load_data       (i_load_data),
        .o_load_ready      (o_load_ready),
        .o_load_done       (o_load_done),
`ifdef EDULENT_LOAD_CHECKSUM_EN
        .o_load_checksum   (o_load_checksum),
`endif
        .o_cpu_rstn        (o_cpu_rstn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one CPU-side vector for one edge and compare the registered read data.
    task automatic apply_vec(input int idx);
        i_mem_addr         = vecs[idx].addr;
        i_mem_write_enable = vecs[idx].we;
        i_mem_data_write   = vecs[idx].wdata;
        tick();
        if (vecs[idx].chk) check($sformatf("vec%0d_read", idx), o_mem_data_read, vecs[idx].exp);
        i_mem_write_enable = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] len);
        i_load_start = 1'b1;
        i_load_len   = len;
        tick();
        i_load_start = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        logic [7:0] sum;

        // read-back after test 1, read-first collision in RUN, backpressure load, full load
        vecs[0]  = '{8'h00, 1'b0, 8'h00, 8'h11, 1'b1};
        vecs[1]  = '{8'h01, 1'b0, 8'h00, 8'hAA, 1'b1};
        vecs[2]  = '{8'h02, 1'b0, 8'h00, 8'h05, 1'b1};
        vecs[3]  = '{8'h7F, 1'b1, 8'h55, 8'h00, 1'b0};
        vecs[4]  = '{8'h7F, 1'b1, 8'h3C, 8'h55, 1'b1};
        vecs[5]  = '{8'h7F, 1'b0, 8'h00, 8'h3C, 1'b1};
        vecs[6]  = '{8'h00, 1'b0, 8'h00, 8'h30, 1'b1};
        vecs[7]  = '{8'h01, 1'b0, 8'h00, 8'h33, 1'b1};
        vecs[8]  = '{8'h02, 1'b0, 8'h00, 8'h34, 1'b1};
        vecs[9]  = '{8'h03, 1'b0, 8'h00, 8'h36, 1'b1};
        vecs[10] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[11] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[12] = '{8'h80, 1'b0, 8'h00, 8'h80, 1'b1};

        rst_n              = 1'b0;
        i_mem_addr         = '0;
        i_mem_write_enable = 1'b0;
        i_mem_data_write   = '0;
        i_load_start       = 1'b0;
        i_load_len         = '0;
        i_load_valid       = 1'b0;
        i_load_data        = '0;
        tick();
        tick();
        check("rst_read", o_mem_data_read, 8'h00);
        check("rst_ready", o_load_ready, 1'b0);
        check("rst_done", o_load_done, 1'b0);
        check("rst_cpu_rstn", o_cpu_rstn, 1'b0);
        rst_n = 1'b1;
        tick();
        check("boot_ready", o_load_ready, 1'b0);

        // Test 1: three-byte back-to-back load
        start_load(8'd3);
        check("t1_ready0", o_load_ready, 1'b1);
        i_load_valid = 1'b1;
        i_load_data  = 8'h11;
        tick();
        check("t1_ready1", o_load_ready, 1'b1);
        i_load_data = 8'hAA;
        tick();
        check("t1_ready2", o_load_ready, 1'b1);
        check("t1_done_early", o_load_done, 1'b0);
        i_load_data = 8'h05;
        tick();
        i_load_valid = 1'b0;
        check("t1_done", o_load_done, 1'b1);
        check("t1_cpu_rstn", o_cpu_rstn, 1'b1);
        check("t1_ready_off", o_load_ready, 1'b0);
`ifdef EDULENT_LOAD_CHECKSUM_EN
        check("t1_checksum", o_load_checksum, 8'hC0);
`endif
        tick();
        check("t1_done_pulse", o_load_done, 1'b0);
        check("t1_cpu_rstn_hold", o_cpu_rstn, 1'b1);
        for (int i = 0; i <= 5; i++) apply_vec(i);

        // Test 3: backpressure, valid pattern 1,0,0,1,1,0,1 (index 0 first)
        start_load(8'd4);
        check("t3_cpu_rstn_drop", o_cpu_rstn, 1'b0);
        check("t3_ready", o_load_ready, 1'b1);
`ifdef EDULENT_LOAD_CHECKSUM_EN
        check("t3_checksum_clr", o_load_checksum, 8'h00);
`endif
        pat = 7'b1011001;
        for (int c = 0; c < 7; c++) begin
            i_load_valid = pat[c];
            i_load_data  = 8'h30 + 8'(c);
            tick();
            check($sformatf("t3_done_c%0d", c), o_load_done, (c == 6) ? 1'b1 : 1'b0);
        end
        i_load_valid = 1'b0;
`ifdef EDULENT_LOAD_CHECKSUM_EN
        check("t3_checksum", o_load_checksum, 8'hCD);
`endif
        for (int i = 6; i <= 9; i++) apply_vec(i);

        // Test 4: len=0 loads all 256 bytes, pointer wraps
        start_load(8'd0);
        sum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'(i);
            sum          = sum + 8'(i);
            tick();
            if (i == 254) check("t4_done_early", o_load_done, 1'b0);
        end
        i_load_valid = 1'b0;
        check("t4_done", o_load_done, 1'b1);
        check("t4_cpu_rstn", o_cpu_rstn, 1'b1);
`ifdef EDULENT_LOAD_CHECKSUM_EN
        check("t4_checksum", o_load_checksum, sum);
`endif
        for (int i = 10; i <= 12; i++) apply_vec(i);

        // Test 5: reset after 2 of 4 bytes
        start_load(8'd4);
        i_load_valid = 1'b1;
        i_load_data  = 8'hA0;
        tick();
        i_load_data = 8'hA1;
        tick();
        i_load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", o_load_ready, 1'b0);
        check("t5_rst_done", o_load_done, 1'b0);
        check("t5_rst_cpu_rstn", o_cpu_rstn, 1'b0);
        check("t5_rst_read", o_mem_data_read, 8'h00);
        #2;
        rst_n = 1'b1;
        i_mem_addr = 8'h00;
        tick();
        check("t5_ready_boot", o_load_ready, 1'b0);
        check("t5_kept_byte", o_mem_data_read, 8'hA0);

        // Test 6: CPU write ignored while CPU is held in reset
        i_mem_addr         = 8'h10;
        i_mem_write_enable = 1'b1;
        i_mem_data_write   = 8'hEE;
        tick();
        i_mem_write_enable = 1'b0;
        tick();
        check("t6_boot_write_ignored", o_mem_data_read, 8'h10);

        // Test 5 continued: new load restarts at address 0
        start_load(8'd4);
        for (int i = 0; i < 4; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'hB0 + 8'(i);
            tick();
        end
        i_load_valid = 1'b0;
        check("t5_done", o_load_done, 1'b1);
        for (int i = 0; i < 5; i++) begin
            i_mem_addr = 8'(i);
            tick();
            check($sformatf("t5_read%0d", i), o_mem_data_read, (i < 4) ? 8'hB0 + 8'(i) : 8'h04);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_edulent_memory
